// File: rtl/window_buffer_if.sv
// Pixel-stream / window handshake bundle between the raster source, the window
// buffer and the downstream Y convolution stage.
interface window_buffer_if #(
  parameter int unsigned BITS_PER_PIXEL = 4
);
  logic                                   sof;
  logic                                   pixel_valid;
  logic [BITS_PER_PIXEL-1:0]              pixel_in;
  logic                                   pixel_ready;
  logic                                   calc_done;
  logic [2:0][2:0][BITS_PER_PIXEL-1:0]    pixels;
  logic                                   calc_enable;
  logic                                   frame_done;

  modport master (
    output sof, pixel_valid, pixel_in, calc_done,
    input  pixel_ready, pixels, calc_enable, frame_done
  );

  modport slave (
    input  sof, pixel_valid, pixel_in, calc_done,
    output pixel_ready, pixels, calc_enable, frame_done
  );
endinterface

// File: rtl/window_buffer.sv
// Raster-scan 3x3 sliding-window buffer feeding the Y convolution stage.
// Define WINDOW_STRIDE3_EN for non-overlapping 3x3 tiles instead of stride 1.
module window_buffer #(
  parameter int unsigned IMG_WIDTH      = 9,
  parameter int unsigned IMG_HEIGHT     = 9,
  parameter int unsigned BITS_PER_PIXEL = 4
) (
  input  logic            clk,
  input  logic            rst,
  window_buffer_if.slave  bus
);

  localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
`ifdef WINDOW_STRIDE3_EN
  localparam int unsigned LAST_COL = (IMG_WIDTH  / 3) * 3 - 1;
  localparam int unsigned LAST_ROW = (IMG_HEIGHT / 3) * 3 - 1;
`else
  localparam int unsigned LAST_COL = IMG_WIDTH  - 1;
  localparam int unsigned LAST_ROW = IMG_HEIGHT - 1;
`endif

  typedef logic [BITS_PER_PIXEL-1:0] pix_t;
  typedef enum logic [1:0] {FILL, ISSUE, WAIT} state_t;

  state_t                               state;
  logic [COL_W-1:0]                     col;
  logic [ROW_W-1:0]                     row;
  pix_t                                 line0 [IMG_WIDTH];
  pix_t                                 line1 [IMG_WIDTH];
  logic [2:0][2:0][BITS_PER_PIXEL-1:0]  window;
  logic                                 ready;
  logic                                 enable;
  logic                                 done_pulse;
  logic                                 calc_done_q;
  logic                                 last_q;

  logic                                 accept;
  logic [COL_W-1:0]                     cur_col;
  logic [ROW_W-1:0]                     cur_row;
  logic                                 win_valid;
  logic                                 win_last;
  logic                                 done_edge;

  // Position of the pixel being accepted this cycle; sof forces it to (0,0).
  always_comb begin
    accept    = bus.pixel_valid && ready;
    cur_col   = bus.sof ? '0 : col;
    cur_row   = bus.sof ? '0 : row;
    done_edge = bus.calc_done && !calc_done_q;
`ifdef WINDOW_STRIDE3_EN
    win_valid = ((cur_col % COL_W'(3)) == COL_W'(2)) &&
                ((cur_row % ROW_W'(3)) == ROW_W'(2));
`else
    win_valid = (cur_col >= COL_W'(2)) && (cur_row >= ROW_W'(2));
`endif
    win_last  = (cur_col == COL_W'(LAST_COL)) && (cur_row == ROW_W'(LAST_ROW));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      ready       <= 1'b1;
      enable      <= 1'b0;
      done_pulse  <= 1'b0;
      window      <= '0;
      col         <= '0;
      row         <= '0;
      calc_done_q <= 1'b0;
      last_q      <= 1'b0;
      line0       <= '{default: '0};
      line1       <= '{default: '0};
    end else begin
      calc_done_q <= bus.calc_done;
      enable      <= 1'b0;
      done_pulse  <= 1'b0;

      if (accept) begin
        line1[cur_col] <= line0[cur_col];
        line0[cur_col] <= bus.pixel_in;
        for (int r = 0; r < 3; r++) begin
          window[r][0] <= window[r][1];
          window[r][1] <= window[r][2];
        end
        window[0][2] <= line1[cur_col];
        window[1][2] <= line0[cur_col];
        window[2][2] <= bus.pixel_in;

        if (cur_col == COL_W'(IMG_WIDTH - 1)) begin
          col <= '0;
          row <= (cur_row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : cur_row + ROW_W'(1);
        end else begin
          col <= cur_col + COL_W'(1);
          row <= cur_row;
        end
      end

      // Window handshake: issue one pulse, then hold until the stage finishes.
      case (state)
        FILL: begin
          if (accept && win_valid) begin
            state  <= ISSUE;
            ready  <= 1'b0;
            enable <= 1'b1;
            last_q <= win_last;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (done_edge) begin
            state <= FILL;
            ready <= 1'b1;
            if (last_q) begin
              done_pulse <= 1'b1;
              col        <= '0;
              row        <= '0;
            end
          end
        end
        default: begin
          state <= FILL;
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pixel_ready = ready;
  assign bus.pixels      = window;
  assign bus.calc_enable = enable;
  assign bus.frame_done  = done_pulse;

endmodule

// File: tb/tb_window_buffer.sv
// Self-checking bench for window_buffer: image-level reference model of windows,
// handshake timing and frame completion, driven by directed and random frames.
module tb_window_buffer;

  localparam int unsigned W   = 9;
  localparam int unsigned H   = 9;
  localparam int unsigned BPP = 4;
  localparam int          LAT = 7;
`ifdef WINDOW_STRIDE3_EN
  localparam int N_WIN   = (H / 3) * (W / 3);
  localparam int N_TRUNC = 3;
`else
  localparam int N_WIN   = (H - 2) * (W - 2);
  localparam int N_TRUNC = 17;
`endif

  typedef logic [2:0][2:0][BPP-1:0] win_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window_buffer_if #(.BITS_PER_PIXEL(BPP)) bus ();

  window_buffer #(
    .IMG_WIDTH     (W),
    .IMG_HEIGHT    (H),
    .BITS_PER_PIXEL(BPP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  int   img [H][W];
  int   m_row = 0, m_col = 0, age = 0, timer = 0;
  bit   busy = 0, last_pend = 0, exp_en = 0, exp_fd = 0, win_known = 0;
  bit   last_acc = 0, cd_prev = 0, phase = 0;
  win_t hold_win, first_win, last_win;
  int   n_en = 0, n_fd = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_win(input int r, input int c);
`ifdef WINDOW_STRIDE3_EN
    return (r % 3 == 2) && (c % 3 == 2);
`else
    return (r >= 2) && (c >= 2);
`endif
  endfunction

  function automatic bit is_last(input int r, input int c);
`ifdef WINDOW_STRIDE3_EN
    return (r == (H / 3) * 3 - 1) && (c == (W / 3) * 3 - 1);
`else
    return (r == H - 1) && (c == W - 1);
`endif
  endfunction

  function automatic win_t win_at(input int r, input int c);
    win_t w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[i][j] = BPP'(img[r - 2 + i][c - 2 + j]);
    return w;
  endfunction

  // One clock: update the image-level model at the edge, then check outputs.
  task automatic tick();
    bit edge_cd;
    int r, c;
    @(posedge clk);
    last_acc = 0;
    edge_cd  = bus.calc_done && !cd_prev;
    if (rst) begin
      busy = 0; m_row = 0; m_col = 0; exp_en = 0; exp_fd = 0;
      hold_win = '0; win_known = 1; cd_prev = 0; timer = 0; age = 0;
    end else begin
      exp_en  = 0;
      exp_fd  = 0;
      cd_prev = bus.calc_done;
      if (bus.pixel_valid && !busy) begin
        last_acc = 1;
        r = bus.sof ? 0 : m_row;
        c = bus.sof ? 0 : m_col;
        img[r][c] = int'(bus.pixel_in);
        if (is_win(r, c)) begin
          busy = 1; age = 0; exp_en = 1; timer = LAT;
          last_pend = is_last(r, c);
          hold_win  = win_at(r, c);
          win_known = 1;
        end else begin
          win_known = 0;
        end
        c++;
        if (c == W) begin
          c = 0; r++;
          if (r == H) r = 0;
        end
        m_row = r; m_col = c;
      end else if (busy) begin
        age++;
        if (age >= 2 && edge_cd) begin
          busy = 0;
          if (last_pend) begin
            exp_fd = 1; m_row = 0; m_col = 0;
          end
        end
      end
    end
    #1;
    chk("calc_enable", 64'(bus.calc_enable), 64'(exp_en));
    chk("frame_done",  64'(bus.frame_done),  64'(exp_fd));
    chk("pixel_ready", 64'(bus.pixel_ready), 64'(!busy));
    if (win_known) chk("pixels", 64'(bus.pixels), 64'(hold_win));
    if (bus.calc_enable === 1'b1) begin
      if (n_en == 0) first_win = bus.pixels;
      last_win = bus.pixels;
      n_en++;
    end
    if (bus.frame_done === 1'b1) n_fd++;
    // Convolution stage stand-in: raise calc_done a fixed latency after issue.
    if (!busy) bus.calc_done = 1'b0;
    else if (timer > 0) begin
      timer--;
      if (timer == 0) bus.calc_done = 1'b1;
    end
  endtask

  // mode 0: pixel=(r+c)%16, else random; gap 0: always valid, 1: alternate, 2: random
  task automatic send(input int n, input int mode, input int gap, input bit first_sof);
    for (int k = 0; k < n; k++) begin
      int unsigned rv;
      int pr, pc, guard;
      bit done;
      rv    = $urandom;
      done  = 0;
      guard = 0;
      bus.sof = first_sof && (k == 0);
      while (!done) begin
        pr = bus.sof ? 0 : m_row;
        pc = bus.sof ? 0 : m_col;
        bus.pixel_in = (mode == 0) ? BPP'((pr + pc) % 16) : BPP'(rv);
        if (gap == 0)      bus.pixel_valid = 1'b1;
        else if (gap == 1) bus.pixel_valid = phase;
        else               bus.pixel_valid = 1'($urandom_range(0, 1));
        phase = !phase;
        tick();
        done = last_acc;
        guard++;
        if (!done && guard > 200) begin
          chk("send_timeout", 64'(guard), 64'(200));
          done = 1;
        end
      end
    end
    bus.sof         = 1'b0;
    bus.pixel_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((busy || bus.calc_done) && guard <= 100) begin
      tick();
      guard++;
    end
    if (guard > 100) chk("drain_timeout", 64'(guard), 64'(100));
  endtask

  initial begin
    rst             = 1'b1;
    bus.sof         = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.pixel_in    = '0;
    bus.calc_done   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_pixels",      64'(bus.pixels),      64'(0));
    chk("rst_calc_enable", 64'(bus.calc_enable), 64'(0));
    chk("rst_frame_done",  64'(bus.frame_done),  64'(0));
    chk("rst_pixel_ready", 64'(bus.pixel_ready), 64'(1));

    // Full directed frame, valid held high through WAIT (backpressure).
    n_en = 0; n_fd = 0;
    send(W * H, 0, 0, 1'b1);
    drain();
    chk("full_count",      64'(n_en),      64'(N_WIN));
    chk("full_frame_done", 64'(n_fd),      64'(1));
    chk("full_first_win",  64'(first_win), 64'(36'h432_321_210));
    chk("full_last_win",   64'(last_win),  64'(36'h0FE_FED_EDC));

    // Same frame with a bubble every other cycle.
    n_en = 0; n_fd = 0;
    send(W * H, 0, 1, 1'b1);
    drain();
    chk("gap_count",      64'(n_en),      64'(N_WIN));
    chk("gap_frame_done", 64'(n_fd),      64'(1));
    chk("gap_first_win",  64'(first_win), 64'(36'h432_321_210));
    chk("gap_last_win",   64'(last_win),  64'(36'h0FE_FED_EDC));

    // Random pixels with random valid.
    n_en = 0; n_fd = 0;
    send(W * H, 1, 2, 1'b1);
    drain();
    chk("rand_count",      64'(n_en), 64'(N_WIN));
    chk("rand_frame_done", 64'(n_fd), 64'(1));

    // Truncated frame: sof arrives where (4,5) would be.
    n_en = 0; n_fd = 0;
    send(4 * W + 5, 1, 2, 1'b1);
    send(W * H, 1, 0, 1'b1);
    drain();
    chk("resync_count",      64'(n_en), 64'(N_TRUNC + N_WIN));
    chk("resync_frame_done", 64'(n_fd), 64'(1));

    // Reset while waiting on the first window of a frame.
    n_en = 0; n_fd = 0;
    send(2 * W + 3, 1, 0, 1'b1);
    tick(); tick(); tick();
    chk("wait_ready_low", 64'(bus.pixel_ready), 64'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_wait_ready", 64'(bus.pixel_ready), 64'(1));
    bus.calc_done = 1'b1;
    repeat (10) tick();
    chk("rst_wait_no_reissue", 64'(n_en), 64'(1));
    chk("rst_wait_no_fd",      64'(n_fd), 64'(0));

    // Clean frame after the reset.
    n_en = 0; n_fd = 0;
    send(W * H, 1, 2, 1'b1);
    drain();
    chk("post_rst_count",      64'(n_en), 64'(N_WIN));
    chk("post_rst_frame_done", 64'(n_fd), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/window_buffer.md
# window_buffer

Raster-scan sliding-window buffer that sits directly upstream of the Y convolution stage. It accepts one 4-bit pixel per handshake and stores the two previous image rows in line buffers. It assembles 3×3 pixel windows, presents each window on `pixels`, pulses `calc_enable`, and holds the window stable until the convolution stage reports `calc_done`.

## Interface
- `IMG_WIDTH`, 9, pixels per row (≥3)
- `IMG_HEIGHT`, 9, rows per frame (≥3)
- `BITS_PER_PIXEL`, 4, pixel width
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `sof`  in  1  start of frame; qualifies the accepted pixel as (row 0, col 0)
- `pixel_valid`  in  1  `pixel_in` is valid
- `pixel_in`  in  BITS_PER_PIXEL  raster-order pixel
- `pixel_ready`  out  1  block can accept a pixel this cycle
- `calc_done`  in  1  convolution result ready; level signal, rising edge is used
- `pixels`  out  [2:0][2:0][BITS_PER_PIXEL-1:0]  window; `[r][c]`, r=0 is the oldest/top row, c=0 is the leftmost column
- `calc_enable`  out  1  one-cycle pulse: the window on `pixels` is new
- `frame_done`  out  1  one-cycle pulse after the last window of the frame completes

## Operation
- Accept a pixel when `pixel_valid && pixel_ready`. Nothing else advances counters or buffers.
- Counters:
  - `col` runs 0..IMG_WIDTH-1 and wraps to 0, incrementing `row`.
  - `row` runs 0..IMG_HEIGHT-1.
  - An accepted pixel with `sof=1` is forced to position (0,0). Counters continue from there.
- Line buffers:
  - Two rows of IMG_WIDTH × BITS_PER_PIXEL, indexed by `col`.
  - On accept, read `line1[col]` and `line0[col]`.
  - Write `line1[col] <= line0[col]` and `line0[col] <= pixel_in`.
- Window register:
  - On accept, shift columns left (c0 ← c1 ← c2).
  - The new column c2 is {r0 = old `line1[col]`, r1 = old `line0[col]`, r2 = `pixel_in`}.
- A window is valid when the accepted pixel has row ≥2 and col ≥2. This gives (IMG_HEIGHT-2)×(IMG_WIDTH-2) windows per frame, 49 for 9×9.
- FSM:
  - FILL: `pixel_ready=1`. An accept that completes a valid window moves to ISSUE. Other accepts stay in FILL.
  - ISSUE (1 cycle): `calc_enable=1`, `pixel_ready=0`. Next state is WAIT.
  - WAIT: `pixel_ready=0`. Leave on a `calc_done` rising edge (`calc_done && !calc_done_q`, where `calc_done_q` is registered every cycle). If the window was the last of the frame (row=IMG_HEIGHT-1, col=IMG_WIDTH-1), pulse `frame_done` and clear counters. Next state is FILL.
- `calc_done` is ignored in FILL and ISSUE. An edge occurring in ISSUE is not latched.
- `pixels` changes only on accepts, so it is stable from ISSUE through WAIT.
- Values are unsigned and pass through unmodified; no arithmetic.

## Timing
- Reset values: `pixels`=0, `calc_enable`=0, `frame_done`=0, state=FILL, so `pixel_ready`=1. Counters, line buffers and `calc_done_q` are 0.
- `pixel_ready` is a decode of the registered state only. It has no combinational path from any input.
- Completing accept at edge N:
  - `calc_enable` is high during cycle N+1.
  - WAIT begins at N+2.
- `calc_done` edge sampled at edge M → `pixel_ready`=1 and `frame_done` (if last window) during cycle M+1.
- Minimum window period is 3 cycles plus the convolution latency.
- `rst` asserted in any state: at the next edge, return to reset values. A pending window is discarded and is not reissued.
- `sof` with a non-accepted pixel has no effect.
- Frames shorter than IMG_HEIGHT rows that are truncated by `sof` produce no `frame_done`.

## Configuration
- `WINDOW_STRIDE3_EN` defined:
  - Non-overlapping 3×3 tiles.
  - A window is valid only when `col%3==2` and `row%3==2`, giving (IMG_HEIGHT/3)×(IMG_WIDTH/3) windows, 9 for 9×9.
  - The last-window test for `frame_done` uses the last tile position.
- Undefined: stride-1 behaviour as above.

## Test plan
- Reset: hold `rst`=1 for 2 cycles, then check `pixels`=0, `calc_enable`=0, `frame_done`=0, `pixel_ready`=1.
- Full 9×9 frame:
  - Stimulus: pixel = (r+c)%16, `pixel_valid` held high, `sof` on the first pixel. Model `calc_done` as rising 7 cycles after `calc_enable`.
  - First `calc_enable` is the cycle after (2,2) is accepted, with `pixels[0]`={0,1,2}, `pixels[1]`={1,2,3}, `pixels[2]`={2,3,4}.
  - Exactly 49 pulses in total. The window at (8,8) has `pixels[2][2]`=0 (16%16).
  - One `frame_done` after the 49th `calc_done`.
- Backpressure: keep `pixel_valid`=1 through WAIT. Check `pixel_ready`=0, no pixel is consumed, and `pixels` stays unchanged for all 7 cycles.
- Gaps: insert `pixel_valid`=0 bubbles every other cycle. Window contents and count are identical to the full-frame case.
- Resync and reset:
  - `sof` at (4,5) mid-frame: no `calc_enable` until the new (2,2) is accepted.
  - `rst` in WAIT: `pixel_ready`=1 next cycle and the pending window is never reissued.
- With `WINDOW_STRIDE3_EN` on the same frame: 9 pulses, windows at tile origins (3m,3n), and `frame_done` after the 9th.
